i2c_data_out: RTL

Transmit-side data engine for the I2C master, the counterpart of the receive-side data path. It takes a parallel buffer of up to 8 bytes and shifts them out on SDA MSB-first, one bit per bit-strobe. After each byte it releases SDA for the target's ACK slot and samples the ACK. It stops early on NACK and reports completion to the master controller, which supplies the bit-phase strobes derived from SCL generation.

---
 rtl/i2c_data_out_if.sv | 37 +++
 rtl/i2c_data_out.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/i2c_data_out_if.sv
// i2c_data_out_if: bundle between the I2C master controller and the
// transmit-side data engine.
//   master modport : controller side, drives the byte buffer, length, start
//                    request, bit-phase strobes and synchronized SDA input;
//                    observes the SDA drive value and transfer status.
//   slave modport  : data engine side (i2c_data_out).
// Handshake: start is a one-cycle request, taken only in a cycle where
// busy=0. There is no ready signal. A request made while busy=1 is dropped.
// Completion is the single-cycle done pulse. busy falls in that same cycle.
// fsm_state exposes the engine's FSM state for observation only.
interface i2c_data_out_if #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
);
  logic [7:0]       data [0:DEPTH-1];
  logic [LEN_W-1:0] length;
  logic             start;
  logic             bit_tick;
  logic             sample_tick;
  logic             din;
  logic             dout;
  logic             busy;
  logic             done;
  logic             nack;
  logic [LEN_W-1:0] byte_count;
  logic [1:0]       fsm_state;

  modport master (
    output data, length, start, bit_tick, sample_tick, din,
    input  dout, busy, done, nack, byte_count, fsm_state
  );

  modport slave (
    input  data, length, start, bit_tick, sample_tick, din,
    output dout, busy, done, nack, byte_count, fsm_state
  );
endinterface

// File: rtl/i2c_data_out.sv
// i2c_data_out: transmit-side data engine of the I2C master.
// The module serializes up to DEPTH buffered bytes onto SDA, MSB first.
// It drives one bit per bit_tick, which marks the SCL-low phase. After each
// byte it releases SDA for the target's ACK. It samples that ACK on
// sample_tick, in the SCL-high phase. A NACK ends the transfer early.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   bus (slave modport)  : data[0:DEPTH-1], length, start, bit_tick,
//                          sample_tick, din in; dout (open-drain sense,
//                          1=release), busy, done, nack, byte_count and
//                          fsm_state out
module i2c_data_out #(
  parameter int DEPTH = 8,
  parameter int LEN_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  i2c_data_out_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    ACK      = 2'd2,
    ACK_WAIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       buf_q [0:DEPTH-1];
  logic [7:0]       buf_d [0:DEPTH-1];
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_nxt;
  logic [2:0]       bit_q, bit_d;
  logic             dout_q, dout_d;
  logic             done_q, done_d;
  logic             nack_q, nack_d;
  logic [LEN_W-1:0] len_clamp;
  logic             last_byte;

  // A requested length beyond the buffer size sends the whole buffer.
  assign len_clamp = (bus.length > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.length;
  assign idx_nxt   = idx_q + IDX_W'(1);
  assign last_byte = (LEN_W'(idx_q) + LEN_W'(1)) == len_q;

  // State register plus datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= 8'h00;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      bit_q   <= 3'd7;
      dout_q  <= 1'b1;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= buf_d[i];
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
    end
  end

  // Next-state logic. bit_tick wins over sample_tick when both arrive together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.start && (len_clamp != '0)) state_d = SHIFT;
      SHIFT:    if (bus.bit_tick && (bit_q == 3'd0)) state_d = ACK;
      ACK:      if (bus.sample_tick && !bus.bit_tick) state_d = ACK_WAIT;
      ACK_WAIT: if (bus.bit_tick) state_d = (nack_q || last_byte) ? IDLE : SHIFT;
      default:  state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    for (int i = 0; i < DEPTH; i++) buf_d[i] = buf_q[i];
    len_d  = len_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    bit_d  = bit_q;
    dout_d = dout_q;
    done_d = 1'b0;
    nack_d = nack_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < DEPTH; i++) buf_d[i] = bus.data[i];
          len_d  = len_clamp;
          nack_d = 1'b0;
          cnt_d  = '0;
          idx_d  = '0;
          bit_d  = 3'd7;
          if (len_clamp == '0) begin
            done_d = 1'b1;
          end else begin
            dout_d = bus.data[0][7];
          end
        end
      end
      SHIFT: begin
        if (bus.bit_tick) begin
          if (bit_q != 3'd0) begin
            bit_d  = bit_q - 3'd1;
            dout_d = buf_q[idx_q][bit_q - 3'd1];
          end else begin
            dout_d = 1'b1;  // release SDA for the ACK slot
          end
        end
      end
      ACK: begin
        if (bus.sample_tick && !bus.bit_tick) begin
          if (!bus.din) cnt_d  = cnt_q + LEN_W'(1);
          else          nack_d = 1'b1;
        end
      end
      ACK_WAIT: begin
        if (bus.bit_tick) begin
          if (nack_q || last_byte) begin
            dout_d = 1'b1;
            done_d = 1'b1;
          end else begin
            idx_d  = idx_nxt;
            bit_d  = 3'd7;
            dout_d = buf_q[idx_nxt][7];
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.nack       = nack_q;
  assign bus.byte_count = cnt_q;
  assign bus.fsm_state  = state_q;

endmodule
